// File: rtl/dsp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_sequencer
// Purpose  : Issues the host-loaded per-frame microprogram to the DSP core on
//            each sample tick, drains the core pipeline with NOPs, flags overruns.
//            Optional overrun counter enabled by macro SEQ_OVERRUN_COUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module dsp_sequencer #(
   parameter int INSTR_WIDTH = 26,
   parameter int PROG_DEPTH  = 1024,
   parameter int PC_WIDTH    = $clog2(PROG_DEPTH),
   parameter int PIPE_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sample_tick,
   input  logic [PC_WIDTH:0]      prog_len,
   input  logic                   prog_wr_en,
   input  logic [PC_WIDTH-1:0]    prog_wr_addr,
   input  logic [INSTR_WIDTH-1:0] prog_wr_data,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun,
   output logic [15:0]            overrun_count
);

   localparam int c_CNT_W        = $clog2(PIPE_DEPTH + 2);
   localparam int c_DRAIN_LAST_I = PIPE_DEPTH + 1;
   localparam int c_ONE_I        = 1;

   localparam logic [PC_WIDTH:0]    c_MAX_LEN    = PROG_DEPTH[PC_WIDTH:0];
   localparam logic [PC_WIDTH:0]    c_LEN_ONE    = c_ONE_I[PC_WIDTH:0];
   localparam logic [PC_WIDTH-1:0]  c_PC_ONE     = c_ONE_I[PC_WIDTH-1:0];
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_ONE_I[c_CNT_W-1:0];
   localparam logic [c_CNT_W-1:0]   c_DRAIN_LAST = c_DRAIN_LAST_I[c_CNT_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [PC_WIDTH-1:0]    r_pc;
   logic [PC_WIDTH-1:0]    w_pc_nxt;
   logic [PC_WIDTH:0]      r_len;
   logic [PC_WIDTH:0]      w_len_nxt;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_rd_en;
   logic                   w_busy;
   logic                   w_frame_done;
   logic                   r_rd_vld;
   logic                   r_overrun;
   logic [INSTR_WIDTH-1:0] r_rd_data;
   logic [PC_WIDTH:0]      w_len_clamp;
   logic [PC_WIDTH:0]      w_last_addr;

   logic [INSTR_WIDTH-1:0] r_mem [PROG_DEPTH];

   assign w_len_clamp = (prog_len > c_MAX_LEN) ? c_MAX_LEN : prog_len;
   assign w_last_addr = r_len - c_LEN_ONE;

   // Program RAM: no reset, read-before-write on a same-address collision.
   always_ff @(posedge clk) begin
      if (prog_wr_en) begin
         r_mem[prog_wr_addr] <= prog_wr_data;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[r_pc];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_rd_vld  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_len     <= w_len_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rd_vld  <= w_rd_en;
         r_overrun <= sample_tick & w_busy;
      end
   end

   // DRAIN spans PIPE_DEPTH+2 cycles: the last program word still on the
   // output, PIPE_DEPTH NOPs, then the frame_done cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_len_nxt    = r_len;
      w_cnt_nxt    = r_cnt;
      w_rd_en      = 1'b0;
      w_busy       = 1'b1;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (sample_tick) begin
               w_len_nxt   = w_len_clamp;
               w_pc_nxt    = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = (w_len_clamp != '0) ? S_RUN : S_DRAIN;
            end
         end
         S_RUN: begin
            w_rd_en = 1'b1;
            if ({1'b0, r_pc} == w_last_addr) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_pc_nxt = r_pc + c_PC_ONE;
            end
         end
         S_DRAIN: begin
            if (r_cnt == c_DRAIN_LAST) begin
               w_frame_done = 1'b1;
               w_state_nxt  = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_busy      = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign instruction = r_rd_vld ? r_rd_data : '0;
   assign busy        = w_busy;
   assign frame_done  = w_frame_done;
   assign overrun     = r_overrun;

`ifdef SEQ_OVERRUN_COUNT_EN
   logic [15:0] r_ovr_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovr_cnt <= '0;
      end else if (r_overrun && (r_ovr_cnt != 16'hFFFF)) begin
         r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end
   end

   assign overrun_count = r_ovr_cnt;
`else
   assign overrun_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_sequencer
// Purpose  : Scoreboard bench for dsp_sequencer with a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_sequencer;

   localparam int IW    = 26;
   localparam int DEPTH = 1024;
   localparam int PW    = 10;
   localparam int PIPE  = 4;

   logic          clk          = 1'b0;
   logic          reset_n      = 1'b0;
   logic          sample_tick  = 1'b0;
   logic [PW:0]   prog_len     = '0;
   logic          prog_wr_en   = 1'b0;
   logic [PW-1:0] prog_wr_addr = '0;
   logic [IW-1:0] prog_wr_data = '0;
   logic [IW-1:0] instruction;
   logic          busy;
   logic          frame_done;
   logic          overrun;
   logic [15:0]   overrun_count;

   dsp_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .sample_tick   (sample_tick),
      .prog_len      (prog_len),
      .prog_wr_en    (prog_wr_en),
      .prog_wr_addr  (prog_wr_addr),
      .prog_wr_data  (prog_wr_data),
      .instruction   (instruction),
      .busy          (busy),
      .frame_done    (frame_done),
      .overrun       (overrun),
      .overrun_count (overrun_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: program image, accepted frames, expected overruns.
   typedef struct {
      int t;
      int len;
   } frame_t;

   logic [IW-1:0] ref_mem [DEPTH];
   frame_t        frames[$];
   logic [IW-1:0] exp_words[$];
   int            ovr_q[$];
   int            ovr_hist[$];
   int            busy_end = -100;

   logic [IW-1:0] got[$];
   int            first_busy = -1;

   task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] want_v);
      n_checks++;
      if (got_v !== want_v) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got_v, want_v, cyc);
      end
   endtask

   function automatic int exp_ovr_count();
      int n;
      n = 0;
`ifdef SEQ_OVERRUN_COUNT_EN
      foreach (ovr_hist[i]) if (ovr_hist[i] < cyc) n++;
      if (n > 65535) n = 65535;
`endif
      return n;
   endfunction

   // A tick in cycle t either starts a frame or, inside a frame, overruns.
   task automatic model_tick(input int t, input int len);
      int l;
      if (t <= busy_end) begin
         ovr_q.push_back(t + 1);
         ovr_hist.push_back(t + 1);
      end else begin
         l = (len > DEPTH) ? DEPTH : len;
         frames.push_back('{t, l});
         for (int i = 0; i < l; i++) exp_words.push_back(ref_mem[i]);
         busy_end = t + 2 + l + PIPE;
      end
   endtask

   task automatic close_frame();
      frame_t        f;
      int            mism;
      logic [IW-1:0] w;
      if (frames.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_done_unexpected: got frame_done at cycle %0d, required none", cyc);
      end else begin
         f = frames.pop_front();
         check("busy_start", 64'(first_busy), 64'(f.t + 1));
         check("frame_done_cycle", 64'(cyc), 64'(f.t + 2 + f.len + PIPE));
         check("frame_length", 64'(got.size()), 64'(f.len + PIPE + 2));
         mism = -1;
         for (int i = 0; i < got.size(); i++) begin
            w = (i >= 1 && i <= f.len) ? exp_words[i-1] : '0;
            if (got[i] !== w && mism < 0) mism = i;
         end
         n_checks++;
         if (mism >= 0) begin
            n_fail++;
            w = (mism >= 1 && mism <= f.len) ? exp_words[mism-1] : '0;
            $display("FAIL frame_stream: tick %0d slot %0d got %0h required %0h",
                     f.t, mism, got[mism], w);
         end
         for (int i = 0; i < f.len; i++) void'(exp_words.pop_front());
      end
      got.delete();
      first_busy = -1;
   endtask

   // Monitor: samples on the falling edge, decoupled from stimulus.
   always @(negedge clk) begin
      if (!reset_n) begin
         check("reset_outputs", 64'({instruction, busy, frame_done, overrun, overrun_count}), 64'd0);
         got.delete();
         first_busy = -1;
      end else begin
         check("overrun_count", 64'(overrun_count), 64'(exp_ovr_count()));
         if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL overrun_missing: got no pulse by cycle %0d, required at %0d", cyc, ovr_q[0]);
            void'(ovr_q.pop_front());
         end
         if (overrun) begin
            if (ovr_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL overrun_unexpected: got pulse at cycle %0d, required none", cyc);
            end else begin
               check("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
            end
         end
         if (busy) begin
            if (first_busy < 0) first_busy = cyc;
            got.push_back(instruction);
            if (frame_done) close_frame();
         end else begin
            check("idle_nop", 64'({instruction, frame_done}), 64'd0);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int len);
      logic [31:0] lv;
      lv          = len;
      prog_len    = lv[PW:0];
      sample_tick = 1'b1;
      model_tick(cyc, len);
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
   endtask

   task automatic tick_at(input int c, input int len);
      wait_until(c);
      pulse(len);
   endtask

   task automatic host_write(input int a, input logic [IW-1:0] d);
      logic [31:0] av;
      av           = a;
      prog_wr_en   = 1'b1;
      prog_wr_addr = av[PW-1:0];
      prog_wr_data = d;
      @(posedge clk);
      #1;
      prog_wr_en   = 1'b0;
      ref_mem[a]   = d;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          t;
      int          len;
      int          ot;
      logic [31:0] rv;
      logic [IW-1:0] prog0 [4];

      prog0[0] = 26'h0400401;
      prog0[1] = 26'h0800802;
      prog0[2] = 26'h1000C03;
      prog0[3] = 26'h1801004;

      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int a = 0; a < DEPTH; a++) begin
         rv = $urandom;
         host_write(a, rv[IW-1:0]);
      end
      for (int a = 0; a < 4; a++) host_write(a, prog0[a]);

      // Basic 4-word frame, then an empty frame.
      wait_until(cyc + 2);
      pulse(4);
      wait_idle_gap(1);
      pulse(0);
      wait_idle_gap(2);

      // Overruns (including on the frame_done cycle), then back-to-back frame.
      t = cyc;
      pulse(4);
      tick_at(t + 5, 9);
      tick_at(t + 7, 0);
      tick_at(t + 10, 3);
      tick_at(t + 11, 2);
      wait_idle_gap(1);
`ifdef SEQ_OVERRUN_COUNT_EN
      check("overrun_count_three", 64'(overrun_count), 64'd3);
`else
      check("overrun_count_three", 64'(overrun_count), 64'd0);
`endif

      // Write to the word being read in that cycle returns the old word.
      t = cyc;
      pulse(4);
      wait_until(t + 3);
      host_write(2, 26'h2AAAAAA);
      wait_idle_gap(1);
      pulse(4);
      wait_idle_gap(1);

      // Length clamp at the RAM depth.
      host_write(DEPTH - 1, 26'h3FFFFFF);
      pulse(1100);
      wait_idle_gap(1);

      for (int it = 0; it < 24; it++) begin
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            rv = $urandom;
            host_write(int'($urandom_range(0, 63)), rv[IW-1:0]);
         end
         len = (it % 10 == 9) ? int'($urandom_range(1000, 2047)) : int'($urandom_range(0, 40));
         t = cyc;
         pulse(len);
         if ($urandom_range(0, 1) == 1) begin
            ot = t + int'($urandom_range(1, busy_end - t));
            tick_at(ot, int'($urandom_range(0, 2047)));
         end
         wait_idle_gap(int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a frame, then replay from prog[0].
      for (int a = 0; a < 4; a++) host_write(a, prog0[a]);
      t = cyc;
      pulse(4);
      wait_until(t + 4);
      reset_n = 1'b0;
      #1;
      check("abort_outputs", 64'({instruction, busy, frame_done}), 64'd0);
      frames.delete();
      exp_words.delete();
      ovr_q.delete();
      ovr_hist.delete();
      busy_end = -100;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_until(cyc + 1);
      pulse(4);
      wait_idle_gap(3);

      check("frames_pending", 64'(frames.size()), 64'd0);
      check("overrun_pending", 64'(ovr_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic wait_idle_gap(input int gap);
      wait_until(busy_end + 1 + gap);
   endtask

endmodule
`default_nettype wire
